// File: rtl/uart_bus_master.sv
// UART-driven bus master: decodes W/R/G frames from a UART receiver,
// performs 32-bit bus writes/reads and returns response bytes.
// Ports:
//   clk, resetn           - clock, synchronous active-low reset
//   rx_data, rx_valid     - received byte and its one-cycle strobe
//   tx_data, tx_start     - byte to transmit and its launch pulse
//   tx_busy               - transmitter busy
//   mem_addr, mem_wdata   - word-aligned bus address, write data
//   mem_wmask, mem_rstrb  - byte write enables, read strobe
//   mem_rdata             - read data, valid the cycle after mem_rstrb
//   cpu_hold              - keeps the CPU off the bus until 'G'
//   frame_err             - sticky unknown-command / timeout flag
module uart_bus_master #(
    parameter int TIMEOUT_CYCLES = 2500000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_busy,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    output logic        mem_rstrb,
    input  logic [31:0] mem_rdata,
    output logic        cpu_hold,
    output logic        frame_err
);
    localparam logic [7:0]  CMD_W   = 8'h57;
    localparam logic [7:0]  CMD_R   = 8'h52;
    localparam logic [7:0]  CMD_G   = 8'h47;
    localparam logic [7:0]  RSP_K   = 8'h4B;
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, ADDR, DATA, WRITE, READ, RWAIT, RESP, TXWAIT
    } state_t;

    state_t      state, state_n;
    logic [1:0]  cnt;
    logic        is_wr;
    logic [31:0] addr, wdata, resp;
    logic [2:0]  left;
    logic        txw;
    logic [31:0] timer;
    logic        hold_q, err_q;
    logic        expire;

    assign tx_data   = resp[7:0];
    assign mem_addr  = addr & 32'hFFFF_FFFC;
    assign mem_wdata = wdata;
    assign cpu_hold  = hold_q;
    assign frame_err = err_q;

    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= state_n;
    end

    always_comb begin
        state_n   = state;
        tx_start  = 1'b0;
        mem_wmask = 4'h0;
        mem_rstrb = 1'b0;
        expire    = 1'b0;
        unique case (state)
            IDLE: begin
                if (rx_valid) begin
                    if (rx_data == CMD_W || rx_data == CMD_R)
                        state_n = ADDR;
                    else if (rx_data == CMD_G)
                        state_n = RESP;
                end
            end
            ADDR: begin
                if (rx_valid) begin
                    if (cnt == 2'd3) state_n = is_wr ? DATA : READ;
                end else if (timer == TO_LAST) begin
                    expire  = 1'b1;
                    state_n = IDLE;
                end
            end
            DATA: begin
                if (rx_valid) begin
                    if (cnt == 2'd3) state_n = WRITE;
                end else if (timer == TO_LAST) begin
                    expire  = 1'b1;
                    state_n = IDLE;
                end
            end
            WRITE: begin
                mem_wmask = 4'hF;
                state_n   = RESP;
            end
            READ: begin
                mem_rstrb = 1'b1;
                state_n   = RWAIT;
            end
            RWAIT: state_n = RESP;
            RESP: begin
                if (!tx_busy) begin
                    tx_start = 1'b1;
                    state_n  = TXWAIT;
                end
            end
            TXWAIT: begin
                // txw skips the first cycle so tx_busy has time to rise
                if (txw && !tx_busy)
                    state_n = (left == 3'd1) ? IDLE : RESP;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt    <= 2'd0;
            is_wr  <= 1'b0;
            addr   <= 32'h0;
            wdata  <= 32'h0;
            resp   <= 32'h0;
            left   <= 3'd0;
            txw    <= 1'b0;
            timer  <= 32'h0;
            hold_q <= 1'b1;
            err_q  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (rx_valid) begin
                        if (rx_data == CMD_W || rx_data == CMD_R) begin
                            cnt   <= 2'd0;
                            is_wr <= (rx_data == CMD_W);
                            timer <= 32'h0;
                        end else if (rx_data == CMD_G) begin
                            hold_q <= 1'b0;
                            resp   <= {24'h0, RSP_K};
                            left   <= 3'd1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ADDR: begin
                    if (rx_valid) begin
                        // LSB arrives first: shift in from the top
                        addr  <= {rx_data, addr[31:8]};
                        cnt   <= cnt + 2'd1;
                        timer <= 32'h0;
                    end else begin
                        timer <= timer + 32'd1;
                    end
                    if (expire) err_q <= 1'b1;
                end
                DATA: begin
                    if (rx_valid) begin
                        wdata <= {rx_data, wdata[31:8]};
                        cnt   <= cnt + 2'd1;
                        timer <= 32'h0;
                    end else begin
                        timer <= timer + 32'd1;
                    end
                    if (expire) err_q <= 1'b1;
                end
                WRITE: begin
                    resp <= {24'h0, RSP_K};
                    left <= 3'd1;
                end
                RWAIT: begin
                    resp <= mem_rdata;
                    left <= 3'd4;
                end
                RESP: txw <= 1'b0;
                TXWAIT: begin
                    if (!txw) begin
                        txw <= 1'b1;
                    end else if (!tx_busy) begin
                        resp <= {8'h0, resp[31:8]};
                        left <= left - 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_bus_master.sv
// Self-checking bench for uart_bus_master: table of frames plus
// hand-written timeout, error, drop and mid-frame reset sequences.
module tb_uart_bus_master;
    localparam int TO = 40;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [7:0]  rx_data = 8'h0;
    logic        rx_valid = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy = 1'b0;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_rstrb;
    logic [31:0] mem_rdata = 32'h0;
    logic        cpu_hold, frame_err;

    uart_bus_master #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .resetn(resetn),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_rstrb(mem_rstrb),
        .mem_rdata(mem_rdata),
        .cpu_hold(cpu_hold), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  txq[$];
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    int          busy_left = 0;
    logic [31:0] last_addr = 32'h0;
    logic [31:0] last_wdata = 32'h0;
    logic [3:0]  last_mask = 4'h0;
    logic [31:0] rd_val = 32'h0;

    typedef struct {
        int          n;
        logic [71:0] frame;
        logic [31:0] rdata;
        int          ntx;
        logic [31:0] tx;
        int          nwr;
        int          nrd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        hold;
    } vec_t;

    vec_t vt[7];

    // Read data appears only in the cycle after the strobe
    always @(posedge clk) mem_rdata <= mem_rstrb ? rd_val : 32'h0;

    // Transmitter model and bus monitor
    always @(negedge clk) begin
        if (tx_start) begin
            n_cmp++;
            if (tx_busy) begin
                n_bad++;
                $display("FAIL tx_start_busy: tx_start=1 while tx_busy=1, required tx_busy=0");
            end
            txq.push_back(tx_data);
            busy_left = 4;
        end else if (busy_left > 0) begin
            busy_left--;
        end
        tx_busy = (busy_left > 0);
        if (mem_wmask != 4'h0) begin
            wr_cnt++;
            last_addr  = mem_addr;
            last_wdata = mem_wdata;
            last_mask  = mem_wmask;
        end
        if (mem_rstrb) begin
            rd_cnt++;
            last_addr = mem_addr;
        end
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_done(input int base, input int n);
        int k = 0;
        while (((txq.size() - base) < n || tx_busy) && k < 400) begin
            @(negedge clk);
            k++;
        end
        check("resp_done", 32'(k < 400), 32'd1);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_tx_start"}, 32'(tx_start), 32'd0);
        check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
        check({tag, "_wmask"}, 32'(mem_wmask), 32'd0);
        check({tag, "_rstrb"}, 32'(mem_rstrb), 32'd0);
        check({tag, "_addr"}, mem_addr, 32'd0);
        check({tag, "_wdata"}, mem_wdata, 32'd0);
        check({tag, "_frame_err"}, 32'(frame_err), 32'd0);
        check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v, input int idx, input logic ferr);
        int b0 = txq.size();
        int w0 = wr_cnt;
        int r0 = rd_cnt;
        rd_val = v.rdata;
        for (int i = 0; i < v.n; i++) send_byte(v.frame[8*i +: 8]);
        wait_done(b0, v.ntx);
        check($sformatf("v%0d_tx_count", idx), 32'(txq.size() - b0),
              32'(v.ntx));
        for (int i = 0; i < v.ntx; i++)
            if (b0 + i < txq.size())
                check($sformatf("v%0d_tx_byte%0d", idx, i),
                      32'(txq[b0+i]), 32'(v.tx[8*i +: 8]));
        check($sformatf("v%0d_writes", idx), 32'(wr_cnt - w0), 32'(v.nwr));
        check($sformatf("v%0d_reads", idx), 32'(rd_cnt - r0), 32'(v.nrd));
        if (v.nwr + v.nrd > 0)
            check($sformatf("v%0d_addr", idx), last_addr, v.addr);
        if (v.nwr > 0) begin
            check($sformatf("v%0d_wdata", idx), last_wdata, v.wdata);
            check($sformatf("v%0d_wmask", idx), 32'(last_mask), 32'hF);
        end
        check($sformatf("v%0d_cpu_hold", idx), 32'(cpu_hold), 32'(v.hold));
        check($sformatf("v%0d_frame_err", idx), 32'(frame_err), 32'(ferr));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int b0, w0, r0, k;
        vt[0] = '{9, 72'hDEADBEEF_00000010_57, 32'h0, 1, 32'h4B, 1, 0,
                  32'h10, 32'hDEADBEEF, 1'b1};
        vt[1] = '{5, 72'h00000010_52, 32'h12345678, 4, 32'h12345678, 0, 1,
                  32'h10, 32'h0, 1'b1};
        vt[2] = '{9, 72'h04030201_00000013_57, 32'h0, 1, 32'h4B, 1, 0,
                  32'h10, 32'h04030201, 1'b1};
        vt[3] = '{5, 72'hFFFFFFFF_52, 32'hA55A3CC3, 4, 32'hA55A3CC3, 0, 1,
                  32'hFFFFFFFC, 32'h0, 1'b1};
        vt[4] = '{1, 72'h47, 32'h0, 1, 32'h4B, 0, 0,
                  32'h0, 32'h0, 1'b0};
        vt[5] = vt[4];
        vt[6] = '{9, 72'hCAFEF00D_00000020_57, 32'h0, 1, 32'h4B, 1, 0,
                  32'h20, 32'hCAFEF00D, 1'b0};

        resetn = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("rst");
        resetn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) run_vec(vt[i], i, 1'b0);

        // Unknown command in IDLE, then a 'G' still works
        send_byte(8'h41);
        repeat (2) @(negedge clk);
        check("bad_cmd_err", 32'(frame_err), 32'd1);
        run_vec(vt[4], 10, 1'b1);

        // Inter-byte timeout inside a write frame
        do_reset();
        w0 = wr_cnt;
        send_byte(8'h57);
        send_byte(8'h10);
        send_byte(8'h00);
        repeat (TO - 5) @(negedge clk);
        check("to_before", 32'(frame_err), 32'd0);
        repeat (15) @(negedge clk);
        check("to_after", 32'(frame_err), 32'd1);
        check("to_no_write", 32'(wr_cnt - w0), 32'd0);
        run_vec(vt[1], 11, 1'b1);

        // Byte arriving during TXWAIT is dropped
        do_reset();
        rd_val = 32'h55667788;
        b0 = txq.size();
        w0 = wr_cnt;
        r0 = rd_cnt;
        send_byte(8'h52);
        send_byte(8'h10);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        k = 0;
        while (txq.size() == b0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("drop_first_tx", 32'(k < 100), 32'd1);
        send_byte(8'h57);
        wait_done(b0, 4);
        check("drop_tx_count", 32'(txq.size() - b0), 32'd4);
        if (txq.size() - b0 == 4) begin
            check("drop_b0", 32'(txq[b0]), 32'h88);
            check("drop_b1", 32'(txq[b0+1]), 32'h77);
            check("drop_b2", 32'(txq[b0+2]), 32'h66);
            check("drop_b3", 32'(txq[b0+3]), 32'h55);
        end
        check("drop_writes", 32'(wr_cnt - w0), 32'd0);
        check("drop_reads", 32'(rd_cnt - r0), 32'd1);
        check("drop_err", 32'(frame_err), 32'd0);

        // Reset in the middle of a frame
        run_vec(vt[4], 12, 1'b0);
        w0 = wr_cnt;
        send_byte(8'h57);
        send_byte(8'h10);
        @(negedge clk);
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        check_reset("mid");
        resetn = 1'b1;
        @(negedge clk);
        check("mid_no_write", 32'(wr_cnt - w0), 32'd0);
        run_vec(vt[0], 13, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_bus_master.md
UART_BUS_MASTER -- requirements
Module: uart_bus_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 2500000, maximum idle clocks allowed between bytes inside a frame (100 ms at 25 MHz).
REQ-002 SHALL have port clk, input, 1, system clock; the block is single-clock and every register is clocked on its rising edge.
REQ-003 SHALL have port resetn, input, 1, synchronous active-low reset.
REQ-004 SHALL have port rx_data, input, 8, byte delivered by the UART receiver.
REQ-005 SHALL have port rx_valid, input, 1, one-cycle pulse marking rx_data as valid.
REQ-006 SHALL have port tx_data, output, 8, byte passed to the UART transmitter.
REQ-007 SHALL have port tx_start, output, 1, one-cycle pulse that launches tx_data.
REQ-008 SHALL have port tx_busy, input, 1, high while the transmitter is sending.
REQ-009 SHALL have port mem_addr, output, 32, bus address, word-aligned, so bits [1:0] are always 0.
REQ-010 SHALL have port mem_wdata, output, 32, bus write data.
REQ-011 SHALL have port mem_wmask, output, 4, bus byte write enables.
REQ-012 SHALL have port mem_rstrb, output, 1, bus read strobe.
REQ-013 SHALL have port mem_rdata, input, 32, bus read data, valid the cycle after mem_rstrb.
REQ-014 SHALL have port cpu_hold, output, 1, high holds the CPU off the bus while the loader owns it.
REQ-015 SHALL have port frame_err, output, 1, sticky flag for an unknown command or an inter-byte timeout.

Function
REQ-016 SHALL accept three command bytes: 0x57 'W' (write), 0x52 'R' (read) and 0x47 'G' (go).
- Write frame: 'W', then 4 address bytes LSB first, then 4 data bytes LSB first.
- Read frame: 'R', then 4 address bytes LSB first.
REQ-017 SHALL implement states IDLE, ADDR, DATA, WRITE, READ, RWAIT, RESP and TXWAIT.
REQ-018 SHALL make these transitions:
- IDLE: 'W' or 'R' goes to ADDR with the byte counter cleared; 'G' drives cpu_hold to 0 and sends 'K'.
- ADDR: after the 4th byte, goes to DATA for 'W' or to READ for 'R'.
- DATA: after the 4th byte, goes to WRITE.
REQ-019 SHALL, in WRITE, drive mem_wmask=4'hF for exactly one cycle with mem_addr={addr[31:2],2'b00} and the assembled mem_wdata, then queue response 'K' (0x4B).
REQ-020 SHALL, in READ, pulse mem_rstrb for one cycle.
- RWAIT then captures mem_rdata on the next cycle.
- The 4 captured bytes are queued LSB first as the response.
REQ-021 SHALL send responses one byte at a time.
- RESP asserts tx_start for one cycle, but only while tx_busy=0.
- TXWAIT waits one cycle, then waits for tx_busy=0.
- When bytes remain, TXWAIT returns to RESP; otherwise it goes to IDLE.
REQ-022 SHALL hold mem_wmask=0 and mem_rstrb=0 in every state other than WRITE and READ respectively.
REQ-023 SHALL, in IDLE, ignore any byte other than 'W', 'R' or 'G' and set frame_err.
REQ-024 SHALL drop rx_valid bytes that arrive in WRITE, READ, RWAIT, RESP or TXWAIT, with no state change.
REQ-025 SHALL handle the inter-byte timeout in ADDR and DATA as follows.
- Count cycles since the last byte.
- At TIMEOUT_CYCLES, abandon the frame, return to IDLE, set frame_err and perform no bus access.
REQ-026 SHALL make a 'G' issued while cpu_hold=0 re-send 'K' with no other effect; bus accesses remain allowed with cpu_hold=0.
REQ-027 SHALL produce a write access 12 cycles after the rx_valid of the last data byte at most, and SHALL start a read response within 3 cycles of the last address byte (READ, RWAIT, RESP).

Reset
REQ-028 SHALL, while resetn=0 at a rising clk edge, force the state to IDLE and all counters and the address, data and response registers to 0.
REQ-029 SHALL, during reset, drive tx_start=0, tx_data=0, mem_wmask=0, mem_rstrb=0, mem_addr=0, mem_wdata=0, frame_err=0 and cpu_hold=1.
REQ-030 SHALL abort any frame or response in progress when reset is asserted, with no further bus pulse or tx_start.

Verification
REQ-031 SHALL verify a write: 57 10 00 00 00 EF BE AD DE -> one cycle with mem_addr=0x00000010, mem_wdata=0xDEADBEEF, mem_wmask=F, then tx byte 0x4B.
REQ-032 SHALL verify a read: 52 10 00 00 00, with mem_rdata=0x12345678 on the cycle after mem_rstrb -> tx bytes 78 56 34 12 in order, each tx_start only while tx_busy=0.
REQ-033 SHALL verify go: 47 after reset -> cpu_hold goes 1->0 and 0x4B is transmitted; a second 47 -> cpu_hold stays 0 and 0x4B is transmitted again.
REQ-034 SHALL verify a timeout: 57 10 00, then a silence of TIMEOUT_CYCLES -> frame_err=1, no wmask pulse, and the next 52 frame completes normally.
REQ-035 SHALL verify error and drop cases: byte 0x41 in IDLE -> frame_err=1 and the state stays IDLE; a byte arriving during TXWAIT -> ignored and the response is unchanged.
REQ-036 SHALL verify reset mid-frame: resetn=0 after 57 10 -> all outputs at reset values and cpu_hold=1, and a following complete write frame behaves exactly as in REQ-031.
